// File: rtl/level_pkg.sv
// Shared types for the level sequencer: FSM state, field widths, the
// per-level rectangle record and the constant level table contents.
package level_pkg;

    localparam int POS_W   = 12;
    localparam int COLOR_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        WIN  = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [POS_W-1:0]   h;
        logic [POS_W-1:0]   v;
        logic [COLOR_W-1:0] color;
    } level_rec_t;

    // Constant rectangle placement per level; anything unknown maps to level 0.
    function automatic level_rec_t level_rom(input logic [31:0] idx);
        level_rec_t r;
        case (idx)
            32'd1:   r = '{h: 12'd500, v: 12'd300, color: 4'hC};
            32'd2:   r = '{h: 12'd20,  v: 12'd440, color: 4'h3};
            32'd3:   r = '{h: 12'd600, v: 12'd20,  color: 4'hF};
            default: r = '{h: 12'd100, v: 12'd80,  color: 4'hA};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/level_table.sv
// Combinational level ROM: maps a level index to the rectangle's
// position and colour. Indices at or beyond NUM_LEVELS return level 0.
module level_table
    import level_pkg::*;
#(
    parameter int NUM_LEVELS = 4,
    parameter int LVL_W      = 4
) (
    input  logic [LVL_W-1:0] idx,
    output level_rec_t       rec
);

    logic [31:0] idx_ext;

    assign idx_ext = 32'(idx);

    // Table lookup with out-of-range indices folded back to the first level.
    always_comb begin
        rec = level_rom(32'd0);
        if (idx_ext < 32'(NUM_LEVELS)) begin
            rec = level_rom(idx_ext);
        end
    end

endmodule

// File: rtl/level_sequencer.sv
// Level sequencer for the destination-rectangle datapath.
// Loads each level's rectangle from level_table, qualifies level_complete
// over HIT_FRAMES consecutive frame ticks, plays a blinking win animation,
// then advances the level (pulsing player_rst) or parks in DONE.
// Optional per-level timeout: define LEVEL_TIMEOUT_EN.
//
// Input pulse semantics: start and frame_tick are single-cycle strobes with
// no back-pressure; a strobe is consumed on the clk edge where it is high and
// only the state current at that edge sees it (LOAD never consumes a tick,
// and start only acts in IDLE and DONE).
module level_sequencer
    import level_pkg::*;
#(
    parameter int NUM_LEVELS     = 4,
    parameter int LVL_W          = 4,
    parameter int HIT_FRAMES     = 3,
    parameter int WIN_FRAMES     = 60,
    parameter int BLINK_PERIOD   = 8,
    parameter int TIMEOUT_FRAMES = 1800
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               level_complete,
    output logic [POS_W-1:0]   hStartPos,
    output logic [POS_W-1:0]   vStartPos,
    output logic [COLOR_W-1:0] rect_color,
    output logic               visible,
    output logic [LVL_W-1:0]   level,
    output logic               player_rst,
    output logic               game_done,
    output logic               timed_out,
    output state_t             state_dbg
);

    localparam logic [3:0]       HIT_T    = 4'(HIT_FRAMES);
    localparam logic [7:0]       WIN_T    = 8'(WIN_FRAMES);
    localparam logic [7:0]       BLINK_T  = 8'(BLINK_PERIOD);
    localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(NUM_LEVELS - 1);

    // Elaboration-time guards on the parameter ranges the counters rely on.
    if ((NUM_LEVELS < 2) || (NUM_LEVELS > 16) || ((2 ** LVL_W) < NUM_LEVELS)) begin : g_bad_levels
        $error("level_sequencer: NUM_LEVELS/LVL_W out of range");
    end
    if ((HIT_FRAMES < 1) || (HIT_FRAMES > 15)) begin : g_bad_hit
        $error("level_sequencer: HIT_FRAMES out of range");
    end
    if ((WIN_FRAMES < 1) || (WIN_FRAMES > 255) || (BLINK_PERIOD < 1) || (BLINK_PERIOD > 255)) begin : g_bad_win
        $error("level_sequencer: WIN_FRAMES/BLINK_PERIOD out of range");
    end
    if (TIMEOUT_FRAMES < 1) begin : g_bad_timeout
        $error("level_sequencer: TIMEOUT_FRAMES out of range");
    end

    state_t     state;
    logic [3:0] hit_cnt;
    logic [7:0] win_cnt;
    logic [7:0] blink_cnt;
    level_rec_t rec;

    // Tick-qualified events; each is only meaningful in its own state.
    logic hit_done;
    logic win_done;
    logic blink_wrap;

    level_table #(
        .NUM_LEVELS (NUM_LEVELS),
        .LVL_W      (LVL_W)
    ) u_table (
        .idx (level),
        .rec (rec)
    );

    assign hit_done   = frame_tick && level_complete && ((hit_cnt + 4'd1) == HIT_T);
    assign win_done   = frame_tick && ((win_cnt + 8'd1) == WIN_T);
    assign blink_wrap = frame_tick && ((blink_cnt + 8'd1) == BLINK_T);

    assign state_dbg = state;

`ifdef LEVEL_TIMEOUT_EN
    localparam int            TO_W = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [TO_W-1:0] TO_T = TO_W'(TIMEOUT_FRAMES);

    logic [TO_W-1:0] to_cnt;
    logic            to_done;
    logic            timed_out_q;

    // A hit completing on the timeout tick takes priority over the timeout.
    assign to_done   = frame_tick && !hit_done && ((to_cnt + TO_W'(1)) == TO_T);
    assign timed_out = timed_out_q;

    // Per-level frame budget: counts ticks in PLAY, cleared in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            timed_out_q <= 1'b0;
        end else begin
            unique case (state)
                LOAD: to_cnt <= '0;
                PLAY: begin
                    if (frame_tick && (to_cnt != TO_T)) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                    if (to_done) begin
                        timed_out_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        timed_out_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic to_done;

    assign to_done   = 1'b0;
    assign timed_out = 1'b0;
`endif

    // Main sequencer: state, level index, registered rectangle outputs and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            level      <= '0;
            hStartPos  <= '0;
            vStartPos  <= '0;
            rect_color <= '0;
            visible    <= 1'b0;
            player_rst <= 1'b0;
            game_done  <= 1'b0;
            hit_cnt    <= '0;
            win_cnt    <= '0;
            blink_cnt  <= '0;
        end else begin
            player_rst <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    hStartPos  <= rec.h;
                    vStartPos  <= rec.v;
                    rect_color <= rec.color;
                    visible    <= 1'b1;
                    player_rst <= 1'b1;
                    hit_cnt    <= '0;
                    win_cnt    <= '0;
                    blink_cnt  <= '0;
                    state      <= PLAY;
                end

                PLAY: begin
                    visible <= 1'b1;
                    if (frame_tick) begin
                        if (!level_complete) begin
                            hit_cnt <= '0;
                        end else if (hit_cnt != HIT_T) begin
                            hit_cnt <= hit_cnt + 4'd1;
                        end
                    end
                    if (hit_done) begin
                        state <= WIN;
                    end else if (to_done) begin
                        game_done <= 1'b1;
                        state     <= DONE;
                    end
                end

                WIN: begin
                    if (frame_tick) begin
                        if (win_cnt != WIN_T) begin
                            win_cnt <= win_cnt + 8'd1;
                        end
                        if (blink_wrap) begin
                            blink_cnt <= '0;
                            visible   <= ~visible;
                        end else begin
                            blink_cnt <= blink_cnt + 8'd1;
                        end
                    end
                    // Animation end overrides any blink toggle on the same tick.
                    if (win_done) begin
                        if (level == LAST_LVL) begin
                            game_done <= 1'b1;
                            visible   <= 1'b1;
                            state     <= DONE;
                        end else begin
                            level <= level + LVL_W'(1);
                            state <= LOAD;
                        end
                    end
                end

                DONE: begin
                    visible   <= 1'b1;
                    game_done <= 1'b1;
                    if (start) begin
                        level     <= '0;
                        game_done <= 1'b0;
                        state     <= LOAD;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
